// File: rtl/enemy_scheduler.sv
// Enemy bout sequencer: paces enemy steps, supplies the LFSR direction bit,
// schedules wind-up/strike/recover attack phases and tracks enemy health.
module enemy_scheduler #(
    parameter int         CALM_DIV    = 25000000,
    parameter int         AGGR_DIV    = 12500000,
    parameter int         CALM_MOVES  = 4,
    parameter int         AGGR_MOVES  = 2,
    parameter int         WINDUP_CYC  = 25000000,
    parameter int         RECOVER_CYC = 25000000,
    parameter int         MAX_HEALTH  = 10,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       speed,
    input  logic       attack,
    input  logic [1:0] enemy_x_pos,
    input  logic [1:0] player_x_pos,
    input  logic       player_punch,
    input  logic       player_dodge,
    output logic       enemy_step,
    output logic       go,
    output logic [3:0] health,
    output logic       windup,
    output logic       strike,
    output logic       player_hit,
    output logic       enemy_hit,
    output logic       round_over
);

    localparam int DIV_MAX   = (CALM_DIV > AGGR_DIV) ? CALM_DIV : AGGR_DIV;
    localparam int MOVE_MAX  = (CALM_MOVES > AGGR_MOVES) ? CALM_MOVES : AGGR_MOVES;
    localparam int PHASE_MAX = (WINDUP_CYC > RECOVER_CYC) ? WINDUP_CYC : RECOVER_CYC;
    localparam int DIV_W     = $clog2(DIV_MAX + 1);
    localparam int MOVE_W    = $clog2(MOVE_MAX + 1);
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

    localparam logic [DIV_W-1:0]   CALM_LIM    = DIV_W'(CALM_DIV - 1);
    localparam logic [DIV_W-1:0]   AGGR_LIM    = DIV_W'(AGGR_DIV - 1);
    localparam logic [MOVE_W-1:0]  CALM_THR    = MOVE_W'(CALM_MOVES - 1);
    localparam logic [MOVE_W-1:0]  AGGR_THR    = MOVE_W'(AGGR_MOVES - 1);
    localparam logic [PHASE_W-1:0] WINDUP_LIM  = PHASE_W'(WINDUP_CYC - 1);
    localparam logic [PHASE_W-1:0] RECOVER_LIM = PHASE_W'(RECOVER_CYC - 1);
    localparam logic [3:0]         FULL_HP     = 4'(MAX_HEALTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_WINDUP,
        S_STRIKE,
        S_RECOVER,
        S_KO
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [MOVE_W-1:0]  move_cnt_q, move_cnt_d;
    logic [PHASE_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [3:0]         health_q, health_d;
    logic               enemy_step_q, enemy_step_d;
    logic               windup_q, windup_d;
    logic               strike_q, strike_d;
    logic               player_hit_q, player_hit_d;
    logic               enemy_hit_q, enemy_hit_d;
    logic               round_over_q, round_over_d;

    logic [DIV_W-1:0]   div_lim;
    logic [MOVE_W-1:0]  move_thr;
    logic               punch_ok;

    assign div_lim  = speed  ? AGGR_LIM : CALM_LIM;
    assign move_thr = attack ? AGGR_THR : CALM_THR;
    assign punch_ok = player_punch && (state_q == S_MOVE || state_q == S_RECOVER)
                      && (enemy_x_pos != 2'd0) && (player_x_pos == enemy_x_pos);

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        move_cnt_d   = move_cnt_q;
        phase_cnt_d  = phase_cnt_q;
        lfsr_d       = lfsr_q;
        health_d     = health_q;
        enemy_step_d = 1'b0;
        player_hit_d = 1'b0;
        enemy_hit_d  = 1'b0;

        // The direction bit only moves after a step has been consumed.
        if (enemy_step_q) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end

        case (state_q)
            S_IDLE, S_KO: begin
                if (start) begin
                    state_d     = S_MOVE;
                    div_cnt_d   = '0;
                    move_cnt_d  = '0;
                    phase_cnt_d = '0;
                    health_d    = FULL_HP;
                end
            end
            S_MOVE: begin
                if (div_cnt_q >= div_lim) begin
                    div_cnt_d    = '0;
                    enemy_step_d = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
                if (enemy_step_q) begin
                    if (move_cnt_q >= move_thr) begin
                        move_cnt_d  = '0;
                        phase_cnt_d = '0;
                        state_d     = S_WINDUP;
                    end else begin
                        move_cnt_d = move_cnt_q + 1'b1;
                    end
                end
            end
            S_WINDUP: begin
                div_cnt_d = '0;
                if (phase_cnt_q == WINDUP_LIM) begin
                    phase_cnt_d  = '0;
                    player_hit_d = ~player_dodge;
                    state_d      = S_STRIKE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            S_STRIKE: begin
                phase_cnt_d = '0;
                state_d     = S_RECOVER;
            end
            S_RECOVER: begin
                if (phase_cnt_q == RECOVER_LIM) begin
                    phase_cnt_d = '0;
                    div_cnt_d   = '0;
                    state_d     = S_MOVE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A landed punch overrides whatever phase change was scheduled above.
        if (punch_ok) begin
            enemy_hit_d = 1'b1;
            health_d    = (health_q == 4'd0) ? 4'd0 : health_q - 4'd1;
            if (health_q <= 4'd1) begin
                state_d = S_KO;
            end
        end

        enemy_step_d = enemy_step_d && (state_d == S_MOVE);
        windup_d     = (state_d == S_WINDUP);
        strike_d     = (state_d == S_STRIKE);
        round_over_d = (state_d == S_KO);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            move_cnt_q   <= '0;
            phase_cnt_q  <= '0;
            lfsr_q       <= SEED;
            health_q     <= FULL_HP;
            enemy_step_q <= 1'b0;
            windup_q     <= 1'b0;
            strike_q     <= 1'b0;
            player_hit_q <= 1'b0;
            enemy_hit_q  <= 1'b0;
            round_over_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            move_cnt_q   <= move_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            lfsr_q       <= lfsr_d;
            health_q     <= health_d;
            enemy_step_q <= enemy_step_d;
            windup_q     <= windup_d;
            strike_q     <= strike_d;
            player_hit_q <= player_hit_d;
            enemy_hit_q  <= enemy_hit_d;
            round_over_q <= round_over_d;
        end
    end

    assign enemy_step = enemy_step_q;
    assign go         = lfsr_q[0];
    assign health     = health_q;
    assign windup     = windup_q;
    assign strike     = strike_q;
    assign player_hit = player_hit_q;
    assign enemy_hit  = enemy_hit_q;
    assign round_over = round_over_q;

endmodule

// File: tb/tb_enemy_scheduler.sv
// Directed bench for enemy_scheduler with shortened timing parameters:
// a per-cycle vector table for one calm bout plus hand-written corner sequences.
module tb_enemy_scheduler;

    typedef struct packed {
        logic       step;
        logic       go;
        logic       windup;
        logic       strike;
        logic       player_hit;
        logic       enemy_hit;
        logic       round_over;
        logic [3:0] health;
    } out_t;

    typedef struct {
        logic       start;
        logic       speed;
        logic       attack;
        logic       punch;
        logic       dodge;
        logic [1:0] ex;
        logic [1:0] px;
        out_t       exp;
    } vec_t;

    localparam int N_VEC = 30;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       speed;
    logic       attack;
    logic [1:0] enemy_x_pos;
    logic [1:0] player_x_pos;
    logic       player_punch;
    logic       player_dodge;
    logic       enemy_step;
    logic       go;
    logic [3:0] health;
    logic       windup;
    logic       strike;
    logic       player_hit;
    logic       enemy_hit;
    logic       round_over;

    int   n_cmp;
    int   n_err;
    vec_t vec [N_VEC];
    out_t got;

    enemy_scheduler #(
        .CALM_DIV   (4),
        .AGGR_DIV   (2),
        .CALM_MOVES (4),
        .AGGR_MOVES (2),
        .WINDUP_CYC (3),
        .RECOVER_CYC(4),
        .MAX_HEALTH (10),
        .SEED       (8'hA5)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .speed       (speed),
        .attack      (attack),
        .enemy_x_pos (enemy_x_pos),
        .player_x_pos(player_x_pos),
        .player_punch(player_punch),
        .player_dodge(player_dodge),
        .enemy_step  (enemy_step),
        .go          (go),
        .health      (health),
        .windup      (windup),
        .strike      (strike),
        .player_hit  (player_hit),
        .enemy_hit   (enemy_hit),
        .round_over  (round_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        check(name, {15'd0, actual}, {15'd0, expected});
    endtask

    task automatic check_hp(input string name, input logic [3:0] actual, input logic [3:0] expected);
        check(name, {12'd0, actual}, {12'd0, expected});
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        start        = 1'b0;
        speed        = 1'b0;
        attack       = 1'b0;
        player_punch = 1'b0;
        player_dodge = 1'b0;
        enemy_x_pos  = 2'd2;
        player_x_pos = 2'd1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_windup(input int budget);
        int n;
        n = 0;
        while (windup !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_bit("windup_reached", windup, 1'b1);
    endtask

    function automatic out_t sample();
        return {enemy_step, go, windup, strike, player_hit, enemy_hit, round_over, health};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        // One calm bout, cycle by cycle. Row i: inputs seen at edge i after start.
        for (int i = 0; i < N_VEC; i++) begin
            vec[i].start          = 1'b0;
            vec[i].speed          = 1'b0;
            vec[i].attack         = 1'b0;
            vec[i].punch          = 1'b0;
            vec[i].dodge          = 1'b0;
            vec[i].ex             = 2'd2;
            vec[i].px             = 2'd1;
            vec[i].exp.step       = (i == 4 || i == 8 || i == 12 || i == 16 || i == 29);
            vec[i].exp.go         = (i <= 4) || (i >= 9 && i <= 12);
            vec[i].exp.windup     = (i >= 17 && i <= 19);
            vec[i].exp.strike     = (i == 20);
            vec[i].exp.player_hit = (i == 20);
            vec[i].exp.enemy_hit  = (i == 6 || i == 22);
            vec[i].exp.round_over = 1'b0;
            vec[i].exp.health     = (i >= 22) ? 4'd8 : (i >= 6) ? 4'd9 : 4'd10;
        end
        vec[0].start  = 1'b1;
        vec[14].start = 1'b1;
        vec[6].punch  = 1'b1;  vec[6].px  = 2'd2;
        vec[10].punch = 1'b1;
        vec[18].punch = 1'b1;  vec[18].px = 2'd2;
        vec[21].punch = 1'b1;  vec[21].px = 2'd2;
        vec[22].punch = 1'b1;  vec[22].px = 2'd2;

        do_reset();
        got = sample();
        check("reset_outputs", {5'd0, got}, {5'd0, 1'b0, 1'b1, 5'b00000, 4'd10});

        for (int i = 0; i < N_VEC; i++) begin
            start        = vec[i].start;
            speed        = vec[i].speed;
            attack       = vec[i].attack;
            player_punch = vec[i].punch;
            player_dodge = vec[i].dodge;
            enemy_x_pos  = vec[i].ex;
            player_x_pos = vec[i].px;
            tick();
            got = sample();
            check($sformatf("calm_bout_cycle%0d", i), {5'd0, got}, {5'd0, vec[i].exp});
        end
        start        = 1'b0;
        player_punch = 1'b0;
        player_x_pos = 2'd1;

        // Second attack of the bout: dodge held on the final wind-up cycle.
        wait_windup(60);
        tick();
        tick();
        check_bit("windup_third_cycle", windup, 1'b1);
        player_dodge = 1'b1;
        tick();
        player_dodge = 1'b0;
        check_bit("dodge_strike", strike, 1'b1);
        check_bit("dodge_player_hit", player_hit, 1'b0);
        check_bit("dodge_windup_done", windup, 1'b0);

        // Aggressive: step every 2 cycles, wind-up after the 2nd step.
        do_reset();
        speed  = 1'b1;
        attack = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            check_bit($sformatf("aggr_step_t%0d", t), enemy_step, (t == 2 || t == 4));
            check_bit($sformatf("aggr_windup_t%0d", t), windup, (t == 5));
        end

        // Speed raised with the divider already past the fast limit.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_bit("toggle_no_step_yet", enemy_step, 1'b0);
        speed = 1'b1;
        tick();
        check_bit("toggle_step_late", enemy_step, 1'b1);
        tick();
        check_bit("toggle_gap", enemy_step, 1'b0);
        tick();
        check_bit("toggle_fast_step", enemy_step, 1'b1);
        speed = 1'b0;

        // Knock-out landing on the same cycle the 4th step would start a wind-up.
        do_reset();
        player_x_pos = 2'd2;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        player_punch = 1'b1;
        for (int t = 1; t <= 9; t++) tick();
        player_punch = 1'b0;
        for (int t = 10; t <= 16; t++) tick();
        check_bit("ko_4th_step", enemy_step, 1'b1);
        check_hp("ko_health_one", health, 4'd1);
        player_punch = 1'b1;
        tick();
        check_bit("ko_round_over", round_over, 1'b1);
        check_bit("ko_not_windup", windup, 1'b0);
        check_hp("ko_health_zero", health, 4'd0);
        check_bit("ko_no_step", enemy_step, 1'b0);
        tick();
        player_punch = 1'b0;
        check_bit("ko_punch_ignored", enemy_hit, 1'b0);
        check_bit("ko_holds", round_over, 1'b1);

        // Restart from KO, take a hit, then reset in the middle of wind-up.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_hp("restart_health", health, 4'd10);
        check_bit("restart_round_over", round_over, 1'b0);
        player_punch = 1'b1;
        tick();
        player_punch = 1'b0;
        check_hp("restart_punch_health", health, 4'd9);
        check_bit("restart_enemy_hit", enemy_hit, 1'b1);
        player_x_pos = 2'd1;
        wait_windup(40);
        tick();
        reset_n = 1'b0;
        tick();
        got = sample();
        check("midwindup_reset", {5'd0, got}, {5'd0, 1'b0, 1'b1, 5'b00000, 4'd10});
        reset_n = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        check_bit("post_reset_idle_step", enemy_step, 1'b0);
        check_bit("post_reset_idle_windup", windup, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/enemy_scheduler.md
Name: enemy_scheduler

Overview:
- Sequences the enemy movement FSM for one bout.
- Generates the FSM step enable at a calm or aggressive rate, supplies a pseudo-random `go` direction bit, and schedules wind-up/strike attack phases after N moves.
- Owns enemy health: applies player punches and reports KO.
- Sits between the player input logic and the enemy movement FSM; its `health` output feeds that FSM's health input.

Parameters:
- CALM_DIV, 25000000, clock cycles per enemy step when speed=0
- AGGR_DIV, 12500000, clock cycles per enemy step when speed=1
- CALM_MOVES, 4, steps between attacks when attack=0
- AGGR_MOVES, 2, steps between attacks when attack=1
- WINDUP_CYC, 25000000, cycles of wind-up telegraph before a strike
- RECOVER_CYC, 25000000, cycles the enemy is open after a strike
- MAX_HEALTH, 10, health loaded at bout start (must be ≤15)
- SEED, 8'hA5, LFSR seed (must be nonzero)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a bout from IDLE or KO
- speed  in  1  from enemy FSM; selects AGGR_DIV
- attack  in  1  from enemy FSM; selects AGGR_MOVES
- enemy_x_pos  in  2  enemy column from FSM (0 = invalid, 1..3)
- player_x_pos  in  2  player column (1..3)
- player_punch  in  1  one-cycle punch pulse
- player_dodge  in  1  level; player is dodging
- enemy_step  out  1  one-cycle enable for the enemy FSM state update
- go  out  1  direction bit for the enemy FSM, stable while enemy_step=1
- health  out  4  current enemy health
- windup  out  1  high during WINDUP
- strike  out  1  one-cycle strike pulse
- player_hit  out  1  one-cycle pulse, strike landed
- enemy_hit  out  1  one-cycle pulse, punch landed
- round_over  out  1  high in KO

Behaviour:
- Reset is a synchronous active-low reset_n on the clock clock.
- All outputs are registered. Reset values:
  - state=IDLE
  - enemy_step=0, windup=0, strike=0, player_hit=0, enemy_hit=0, round_over=0
  - health=MAX_HEALTH, lfsr=SEED, go=SEED[0]
  - div_cnt=0, move_cnt=0, phase_cnt=0
- Reset mid-operation abandons any phase immediately.
- go = lfsr[0]. The LFSR is 8-bit and shifts left with feedback = b7^b5^b4^b3 into bit 0. It advances only on cycles where enemy_step=1, so go is constant during a step.
- States: IDLE, MOVE, WINDUP, STRIKE, RECOVER, KO.
- IDLE: outputs idle. On start: go to MOVE, clear div_cnt and move_cnt.
- MOVE:
  - div = speed ? AGGR_DIV : CALM_DIV.
  - If div_cnt >= div-1: div_cnt<=0 and enemy_step<=1. Otherwise div_cnt++ and enemy_step<=0.
  - Step period is therefore div cycles. Using >= means a speed change mid-count fires at most one cycle late.
  - On a cycle with enemy_step=1: thr = attack ? AGGR_MOVES : CALM_MOVES.
    - If move_cnt >= thr-1: move_cnt<=0, go to WINDUP (entered the cycle after the Nth step pulse).
    - Otherwise move_cnt++.
- WINDUP:
  - windup=1 for exactly WINDUP_CYC cycles; no steps.
  - On the last cycle: go to STRIKE, set strike<=1 and player_hit<=~player_dodge. Dodge is sampled on the final WINDUP cycle.
- STRIKE: one cycle with strike=1 (and player_hit if set), then RECOVER.
- RECOVER: exactly RECOVER_CYC cycles with no steps, then MOVE with div_cnt=0.
- Punch:
  - Counted only in MOVE or RECOVER, and only if enemy_x_pos!=0 and player_x_pos==enemy_x_pos.
  - Effect: health<=health-1 (saturating at 0) and enemy_hit<=1 for one cycle.
  - Ignored in IDLE, WINDUP, STRIKE and KO.
- KO:
  - Entered the cycle after health reaches 0.
  - KO has priority over a same-cycle MOVE→WINDUP transition or RECOVER expiry.
  - round_over=1; no steps or pulses.
  - On start: health<=MAX_HEALTH, counters cleared, go to MOVE. The LFSR is not reseeded.
- start is ignored outside IDLE and KO.

Test Plan:
- Params CALM_DIV=4, AGGR_DIV=2, WINDUP_CYC=3, RECOVER_CYC=4, speed=attack=0; reset then start → health=10; enemy_step pulses every 4 cycles; 1 cycle after the 4th pulse windup=1 for 3 cycles, strike 1 cycle, then 4 idle cycles, then steps resume.
- Same setup, observe go at each step → go values 1,0,1,0 for the first four steps (lfsr A5→4A→95→2A).
- player_dodge=0 on the last WINDUP cycle → player_hit=1 with strike; repeat with dodge=1 → strike=1, player_hit=0.
- Punch in MOVE with enemy_x_pos=player_x_pos=2 → health 10→9 and enemy_hit pulses; punch during WINDUP or with x mismatch → health unchanged, no enemy_hit.
- speed=attack=1 → step every 2 cycles; WINDUP after 2 steps; toggle speed mid-count → next step within ≤1 extra cycle.
- Health 1, punch on the cycle of the Nth step → KO (not WINDUP), round_over=1, health=0; start → health=10, MOVE; reset_n=0 mid-WINDUP → all reset values on the next cycle.
